// File: rtl/clk_div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_div_mon_pkg;

  // Default counter width for period, high-time and error counters.
  localparam int CNT_W_DEF = 8;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_MEAS = 2'd2
  } mon_state_t;

  // Absolute difference of two counts. Evaluated in 32-bit signed
  // arithmetic, which is wider than any counter, so the subtraction
  // never wraps below zero.
  function automatic int abs_diff(input int a, input int b);
    int d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

endpackage

// File: rtl/clk_div_monitor_edge_sampler.sv
// Two-flop sampler for a divided-clock tap, with one-cycle rise/fall strobes.
module edge_sampler (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;

  // Sample the tap and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= sig_in;
      s2_reg <= s1_reg;
    end
  end

  assign level = s1_reg;
  assign rise  = s1_reg & ~s2_reg;
  assign fall  = ~s1_reg & s2_reg;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in source-clock cycles,
// checks them against expected values, tracks lock and counts errors.
// Pipeline: sample (s1) -> rise seen / capture -> compare -> outputs,
// so meas_valid lands 3 cycles after clk_div_in is first sampled high.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = 4,
  parameter int EXP_HIGH   = 2,
  parameter int TOL        = 0,
  parameter int LOCK_NUM   = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_div_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_timeout,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_NUM);

  logic s1;
  logic rise;
  logic fall_unused;

  edge_sampler u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (clk_div_in),
    .level  (s1),
    .rise   (rise),
    .fall   (fall_unused)
  );

  mon_state_t       state_reg, state_next;
  logic             tmo_fire;
  logic             meas_fire;

  logic [CNT_W-1:0] per_c_reg;
  logic [CNT_W-1:0] hi_c_reg;
  logic [CNT_W-1:0] to_c_reg;

  logic             cap_vld_reg;
  logic [CNT_W-1:0] cap_per_reg;
  logic [CNT_W-1:0] cap_hi_reg;

  logic             cmp_vld_reg;
  logic [CNT_W-1:0] cmp_per_reg;
  logic [CNT_W-1:0] cmp_hi_reg;
  logic             cmp_eper_reg;
  logic             cmp_eduty_reg;

  logic [CNT_W-1:0] good_run_reg;
  logic [CNT_W-1:0] good_run_next;
  logic             meas_err;
  logic             any_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state plus the rise/timeout events. A rise in the same cycle as
  // the timeout boundary wins and is measured normally.
  always_comb begin
    state_next = state_reg;
    tmo_fire   = 1'b0;
    meas_fire  = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_SYNC;
        ST_SYNC: begin
          if (rise)                     state_next = ST_MEAS;
          else if (to_c_reg == TO_LAST) tmo_fire   = 1'b1;
        end
        ST_MEAS: begin
          if (rise) begin
            meas_fire = 1'b1;
          end else if (to_c_reg == TO_LAST) begin
            tmo_fire   = 1'b1;
            state_next = ST_SYNC;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Period, high-time and no-edge counters; a rise reloads the
  // period/high counters to 1 because the rise cycle itself is high.
  always_ff @(posedge clk) begin
    if (rst || !en || state_reg == ST_IDLE) begin
      per_c_reg <= '0;
      hi_c_reg  <= '0;
      to_c_reg  <= '0;
    end else if (rise) begin
      per_c_reg <= CNT_ONE;
      hi_c_reg  <= CNT_ONE;
      to_c_reg  <= '0;
    end else if (tmo_fire) begin
      per_c_reg <= '0;
      hi_c_reg  <= '0;
      to_c_reg  <= '0;
    end else begin
      to_c_reg <= to_c_reg + CNT_ONE;
      if (state_reg == ST_MEAS) begin
        if (per_c_reg != CNT_MAX)       per_c_reg <= per_c_reg + CNT_ONE;
        if (s1 && hi_c_reg != CNT_MAX)  hi_c_reg  <= hi_c_reg + CNT_ONE;
      end
    end
  end

  // Capture stage: freeze the finished period's counts on a measured rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_reg <= 1'b0;
      cap_per_reg <= '0;
      cap_hi_reg  <= '0;
    end else begin
      cap_vld_reg <= meas_fire;
      if (meas_fire) begin
        cap_per_reg <= per_c_reg;
        cap_hi_reg  <= hi_c_reg;
      end
    end
  end

  // Compare stage: tolerance checks against the expected period/high time.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_vld_reg   <= 1'b0;
      cmp_per_reg   <= '0;
      cmp_hi_reg    <= '0;
      cmp_eper_reg  <= 1'b0;
      cmp_eduty_reg <= 1'b0;
    end else begin
      cmp_vld_reg   <= cap_vld_reg & en;
      cmp_per_reg   <= cap_per_reg;
      cmp_hi_reg    <= cap_hi_reg;
      cmp_eper_reg  <= abs_diff(int'(cap_per_reg), EXP_PERIOD) > TOL;
      cmp_eduty_reg <= abs_diff(int'(cap_hi_reg), EXP_HIGH) > TOL;
    end
  end

  assign meas_err      = cmp_vld_reg & (cmp_eper_reg | cmp_eduty_reg);
  assign any_err       = tmo_fire | (en & meas_err);
  assign good_run_next = (good_run_reg == LOCK_VAL) ? good_run_reg
                                                    : good_run_reg + CNT_ONE;

  // Output stage: publish measurements and pulses; measurements hold while
  // disabled so the last result stays readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt  <= '0;
      high_cnt    <= '0;
      meas_valid  <= 1'b0;
      err_period  <= 1'b0;
      err_duty    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      meas_valid  <= en & cmp_vld_reg;
      err_period  <= en & cmp_vld_reg & cmp_eper_reg;
      err_duty    <= en & cmp_vld_reg & cmp_eduty_reg;
      err_timeout <= tmo_fire;
      if (en && cmp_vld_reg) begin
        period_cnt <= cmp_per_reg;
        high_cnt   <= cmp_hi_reg;
      end
    end
  end

  // Lock tracking: consecutive good measurements build the run; any error
  // or a disable clears it in the same cycle the error pulse is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_run_reg <= '0;
      locked       <= 1'b0;
    end else if (!en || any_err) begin
      good_run_reg <= '0;
      locked       <= 1'b0;
    end else if (cmp_vld_reg) begin
      good_run_reg <= good_run_next;
      if (good_run_next == LOCK_VAL) locked <= 1'b1;
    end
  end

  // Saturating error counter; simultaneous pulses count once.
  always_ff @(posedge clk) begin
    if (rst)                               err_count <= '0;
    else if (any_err && err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor. Five instances share clk/rst/en and the
// divided-clock input; each test resets all of them and checks the instance
// whose parameters it targets.
// Timing reference: a value driven to div right after sample point d is
// sampled into s1 at the next edge (d+1), the FSM sees the rise at d+2, and
// meas_valid is observed at sample point d+4. A timeout fires 255 cycles after
// the FSM-visible rise, i.e. at sample point d+257 with defaults.
module tb_clk_div_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic div = 1'b0;

  logic [7:0] pc [4];
  logic [7:0] hc [4];
  logic [7:0] ec [4];
  logic [3:0] pc4, hc4, ec4;
  logic       mv [5];
  logic       ep [5];
  logic       ed [5];
  logic       et [5];
  logic       lk [5];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_mv [5];
  int n_ep [5];
  int n_ed [5];
  int n_to [5];
  int first_mv [5];
  int first_to [5];
  int lock_at  [5];
  int t_r;

  always #5 clk = ~clk;

  // u0: defaults (period 4, high 2)
  clk_div_monitor u0 (.clk(clk), .rst(rst), .en(en), .clk_div_in(div),
    .period_cnt(pc[0]), .high_cnt(hc[0]), .meas_valid(mv[0]), .err_period(ep[0]),
    .err_duty(ed[0]), .err_timeout(et[0]), .locked(lk[0]), .err_count(ec[0]));
  // u1: 2-high/3-low divide-by-5 expected
  clk_div_monitor #(.EXP_PERIOD(5), .EXP_HIGH(2)) u1 (.clk(clk), .rst(rst), .en(en),
    .clk_div_in(div), .period_cnt(pc[1]), .high_cnt(hc[1]), .meas_valid(mv[1]),
    .err_period(ep[1]), .err_duty(ed[1]), .err_timeout(et[1]), .locked(lk[1]),
    .err_count(ec[1]));
  // u2: same waveform but expecting 3 high -> duty error each period
  clk_div_monitor #(.EXP_PERIOD(5), .EXP_HIGH(3)) u2 (.clk(clk), .rst(rst), .en(en),
    .clk_div_in(div), .period_cnt(pc[2]), .high_cnt(hc[2]), .meas_valid(mv[2]),
    .err_period(ep[2]), .err_duty(ed[2]), .err_timeout(et[2]), .locked(lk[2]),
    .err_count(ec[2]));
  // u3: tolerance 1
  clk_div_monitor #(.TOL(1)) u3 (.clk(clk), .rst(rst), .en(en), .clk_div_in(div),
    .period_cnt(pc[3]), .high_cnt(hc[3]), .meas_valid(mv[3]), .err_period(ep[3]),
    .err_duty(ed[3]), .err_timeout(et[3]), .locked(lk[3]), .err_count(ec[3]));
  // u4: 4-bit counters, timeout 15
  clk_div_monitor #(.CNT_W(4), .TIMEOUT(15)) u4 (.clk(clk), .rst(rst), .en(en),
    .clk_div_in(div), .period_cnt(pc4), .high_cnt(hc4), .meas_valid(mv[4]),
    .err_period(ep[4]), .err_duty(ed[4]), .err_timeout(et[4]), .locked(lk[4]),
    .err_count(ec4));

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 5; i++) begin
      n_mv[i] = 0; n_ep[i] = 0; n_ed[i] = 0; n_to[i] = 0;
      first_mv[i] = -1; first_to[i] = -1; lock_at[i] = -1;
    end
  endtask

  // One clock: sample 1 time unit after the edge and log events.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 5; i++) begin
      if (mv[i]) begin
        n_mv[i]++;
        if (first_mv[i] < 0) first_mv[i] = cyc;
      end
      if (ep[i]) n_ep[i]++;
      if (ed[i]) n_ed[i]++;
      if (et[i]) begin
        n_to[i]++;
        if (first_to[i] < 0) first_to[i] = cyc;
      end
      if (lk[i] && lock_at[i] < 0) lock_at[i] = n_mv[i];
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wave(input int hi, input int lo);
    div = 1'b1;
    ticks(hi);
    div = 1'b0;
    ticks(lo);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
  endtask

  initial begin
    clr();
    // ---- reset state ----
    en = 1'b0; div = 1'b0;
    do_reset();
    check("rst_period_cnt", int'(pc[0]), 0);
    check("rst_locked", int'(lk[0]), 0);
    check("rst_err_count", int'(ec[0]), 0);
    check("rst_meas_valid", int'(mv[0]), 0);

    // ---- divide-by-4, defaults ----
    en = 1'b1;
    ticks(3);
    wave(2, 2);                      // first rise only synchronises
    t_r = cyc;
    repeat (5) wave(2, 2);
    check("div4_first_mv_latency", first_mv[0], t_r + 4);
    check("div4_meas_count", n_mv[0], 5);
    check("div4_period_cnt", int'(pc[0]), 4);
    check("div4_high_cnt", int'(hc[0]), 2);
    check("div4_errors", n_ep[0] + n_ed[0] + n_to[0], 0);
    check("div4_lock_at_meas", lock_at[0], 3);

    // ---- stuck high after lock -> timeout ----
    clr();
    t_r = cyc;
    div = 1'b1;
    ticks(300);
    check("stuck_meas_of_last_rise", n_mv[0], 1);
    check("stuck_timeout_time", first_to[0], t_r + 257);
    check("stuck_timeout_count", n_to[0], 1);
    check("stuck_locked_cleared", int'(lk[0]), 0);
    check("stuck_err_count", int'(ec[0]), 1);
    clr();
    div = 1'b0;
    ticks(2);
    wave(2, 2);                      // back in SYNC: discarded
    t_r = cyc;
    wave(2, 2);
    wave(2, 2);
    check("restart_first_mv", first_mv[0], t_r + 4);

    // ---- divide-by-5, 2 high / 3 low ----
    do_reset();
    en = 1'b1;
    ticks(3);
    repeat (6) wave(2, 3);
    check("div5_meas_count", n_mv[1], 5);
    check("div5_period_cnt", int'(pc[1]), 5);
    check("div5_high_cnt", int'(hc[1]), 2);
    check("div5_lock_at_meas", lock_at[1], 3);
    check("div5_no_errors", n_ep[1] + n_ed[1], 0);
    check("div5h3_duty_errs", n_ed[2], 5);
    check("div5h3_period_errs", n_ep[2], 0);
    check("div5h3_err_count", int'(ec[2]), 5);
    check("div5h3_locked", int'(lk[2]), 0);

    // ---- tolerance 1: periods 4/5 accepted, 6 rejected ----
    do_reset();
    en = 1'b1;
    ticks(3);
    wave(2, 2); wave(2, 3); wave(2, 2); wave(2, 3); wave(2, 2);
    check("tol_locked", int'(lk[3]), 1);
    check("tol_no_errors", n_ep[3] + n_ed[3], 0);
    wave(2, 4);                      // the 6-cycle period
    wave(2, 2);                      // its rise reports the bad period
    check("tol_bad_err_period", n_ep[3], 1);
    check("tol_bad_err_count", int'(ec[3]), 1);
    check("tol_bad_locked", int'(lk[3]), 0);
    repeat (3) wave(2, 2);
    check("tol_relock", int'(lk[3]), 1);
    check("tol_err_count_after", int'(ec[3]), 1);

    // ---- reset mid-MEAS, then enable low for 10 cycles ----
    do_reset();
    en = 1'b1;
    ticks(3);
    repeat (5) wave(2, 2);
    check("rst_pre_locked", int'(lk[0]), 1);
    div = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_period_cnt", int'(pc[0]), 0);
    check("midrst_high_cnt", int'(hc[0]), 0);
    check("midrst_locked", int'(lk[0]), 0);
    check("midrst_pulses", int'(mv[0]) + int'(ep[0]) + int'(ed[0]) + int'(et[0]), 0);
    check("midrst_err_count", int'(ec[0]), 0);
    tick();
    div = 1'b0;
    ticks(2);
    repeat (4) wave(2, 2);
    check("reen_locked", int'(lk[0]), 1);
    clr();
    en = 1'b0;
    wave(2, 2); wave(2, 2); ticks(2);
    check("en_low_no_meas", n_mv[0], 0);
    check("en_low_period_hold", int'(pc[0]), 4);
    check("en_low_locked", int'(lk[0]), 0);
    en = 1'b1;
    wave(2, 2);
    check("en_high_first_edge", n_mv[0], 0);
    wave(2, 2);
    check("en_high_second_edge", n_mv[0], 1);

    // ---- 4-bit saturation and timeout boundary ----
    do_reset();
    en = 1'b1;
    ticks(3);
    repeat (18) wave(1, 2);
    ticks(2);
    check("sat_err_period_pulses", n_ep[4], 17);
    check("sat_err_count", int'(ec4), 15);
    clr();
    wave(1, 14); wave(1, 14); wave(1, 2);
    ticks(2);
    check("p15_period_cnt_prev", n_mv[4], 3);
    check("p15_no_timeout", n_to[4], 0);
    clr();
    wave(1, 14); wave(1, 3);
    check("p15_period_cnt", int'(pc4), 15);
    check("p15_high_cnt", int'(hc4), 1);
    clr();
    wave(1, 19);
    check("p20_timeout", n_to[4], 1);
    check("p20_err_count_sat", int'(ec4), 15);
    check("p20_locked", int'(lk[4]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
